riscv_ifq: RTL and testbench

RISCV_IFQ -- requirements
Module: riscv_ifq

---
 rtl/riscv_ifq_pkg.sv | 15 +
 rtl/riscv_ifq_ram.sv | 37 +++
 rtl/riscv_ifq.sv | 150 +++++++++++++++
 tb/tb_riscv_ifq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ifq_pkg.sv
// Shared instruction-fetch definitions (the riscv_define widths): bus widths,
// default queue depth and the fetch-queue control state encoding.
package riscv_ifq_pkg;

  localparam int InstAddrBus     = 32;
  localparam int InstBus         = 32;
  localparam int IfqDepthDefault = 4;
  localparam int IfqSlotW        = InstAddrBus + InstBus;

  typedef enum logic {
    IFQ_RUN   = 1'b0,
    IFQ_DRAIN = 1'b1
  } ifq_state_e;

endpackage

// File: rtl/riscv_ifq_ram.sv
// Fetch-queue slot storage: {pc, instr} per slot, PC half written at allocation,
// instruction half written at fill, asynchronous read of the head slot.
module riscv_ifq_ram
  import riscv_ifq_pkg::*;
#(
  parameter  int DEPTH = IfqDepthDefault,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   alloc_we_i,
  input  logic [AW-1:0]          alloc_idx_i,
  input  logic [InstAddrBus-1:0] alloc_pc_i,
  input  logic                   fill_we_i,
  input  logic [AW-1:0]          fill_idx_i,
  input  logic [InstBus-1:0]     fill_instr_i,
  input  logic [AW-1:0]          rd_idx_i,
  output logic [InstAddrBus-1:0] rd_pc_o,
  output logic [InstBus-1:0]     rd_instr_o
);

  logic [IfqSlotW-1:0] mem_q [DEPTH];

  // Both ports never target the same slot in one cycle: a slot is only filled
  // while it has an outstanding request, and it cannot be reallocated then.
  always_ff @(posedge clk) begin
    if (alloc_we_i) begin
      mem_q[alloc_idx_i][IfqSlotW-1:InstBus] <= alloc_pc_i;
    end
    if (fill_we_i) begin
      mem_q[fill_idx_i][InstBus-1:0] <= fill_instr_i;
    end
  end

  assign rd_pc_o    = mem_q[rd_idx_i][IfqSlotW-1:InstBus];
  assign rd_instr_o = mem_q[rd_idx_i][InstBus-1:0];

endmodule

// File: rtl/riscv_ifq.sv
// Instruction fetch queue between the PC register, instruction memory and decode.
// Define RISCV_IFQ_BYPASS_EN to forward a response straight to decode when the queue head awaits it.
module riscv_ifq
  import riscv_ifq_pkg::*;
#(
  parameter int DEPTH = IfqDepthDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  output logic                   pc_stall_o,
  input  logic                   flush_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic                   dec_valid_o,
  output logic [InstAddrBus-1:0] dec_pc_o,
  output logic [InstBus-1:0]     dec_instr_o,
  input  logic                   dec_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DepthCmp = (PW+1)'(DEPTH);

  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    read_q, read_d;
  logic [PW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  ifq_state_e       state_q, state_d;

  logic [PW-1:0]    used_cnt;
  logic [PW-1:0]    outstanding;
  logic [PW:0]      req_load;
  logic [AW-1:0]    alloc_idx, fill_idx, read_idx;
  logic             alloc_fire;
  logic             rsp_keep;
  logic             fill_store;
  logic             slot_alloc;
  logic             slot_ready;
  logic             bypass_hit;
  logic             dec_fire;
  logic [InstAddrBus-1:0] rd_pc;
  logic [InstBus-1:0]     rd_instr;

  assign alloc_idx   = alloc_q[AW-1:0];
  assign fill_idx    = fill_q[AW-1:0];
  assign read_idx    = read_q[AW-1:0];
  assign used_cnt    = alloc_q - read_q;
  assign outstanding = alloc_q - fill_q;

  // Responses still owed to a flushed stream reserve slots so the total in
  // flight can never exceed the queue depth.
  assign req_load    = {1'b0, used_cnt} + {1'b0, drop_cnt_q};
  assign imem_req_o  = !rst && !flush_i && (req_load < DepthCmp);
  assign imem_addr_o = pc_i;
  assign alloc_fire  = imem_req_o && imem_gnt_i;
  assign pc_stall_o  = rst || (!alloc_fire && !flush_i);

  assign rsp_keep    = imem_rvalid_i && (state_q == IFQ_RUN) && !flush_i && !rst;
  assign slot_alloc  = (read_q != alloc_q);
  assign slot_ready  = slot_alloc && filled_q[read_idx];

`ifdef RISCV_IFQ_BYPASS_EN
  assign bypass_hit  = rsp_keep && (fill_q == read_q) && slot_alloc && !filled_q[read_idx];
`else
  assign bypass_hit  = 1'b0;
`endif

  assign dec_valid_o = !rst && !flush_i && (slot_ready || bypass_hit);
  assign dec_pc_o    = rd_pc;
  assign dec_instr_o = bypass_hit ? imem_rdata_i : rd_instr;
  assign dec_fire    = dec_valid_o && dec_ready_i;

  // A forwarded response that decode takes at once never lands in the slot.
  assign fill_store  = rsp_keep && !(bypass_hit && dec_ready_i);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_filled
      assign filled_d[gi] = (alloc_fire && (alloc_idx == AW'(gi))) ? 1'b0 :
                            (fill_store && (fill_idx == AW'(gi)))  ? 1'b1 :
                            filled_q[gi];
    end
  endgenerate

  always_comb begin
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    read_d     = read_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      alloc_d    = '0;
      fill_d     = '0;
      read_d     = '0;
      drop_cnt_d = drop_cnt_q + outstanding - PW'(imem_rvalid_i);
    end else begin
      if (alloc_fire) begin
        alloc_d = alloc_q + PW'(1);
      end
      if (rsp_keep) begin
        fill_d = fill_q + PW'(1);
      end
      if (imem_rvalid_i && (state_q == IFQ_DRAIN)) begin
        drop_cnt_d = drop_cnt_q - PW'(1);
      end
      if (dec_fire) begin
        read_d = read_q + PW'(1);
      end
    end
    state_d = (drop_cnt_d == '0) ? IFQ_RUN : IFQ_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q    <= '0;
      fill_q     <= '0;
      read_q     <= '0;
      drop_cnt_q <= '0;
      filled_q   <= '0;
      state_q    <= IFQ_RUN;
    end else begin
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      read_q     <= read_d;
      drop_cnt_q <= drop_cnt_d;
      filled_q   <= filled_d;
      state_q    <= state_d;
    end
  end

  riscv_ifq_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk         (clk),
    .alloc_we_i  (alloc_fire),
    .alloc_idx_i (alloc_idx),
    .alloc_pc_i  (pc_i),
    .fill_we_i   (fill_store),
    .fill_idx_i  (fill_idx),
    .fill_instr_i(imem_rdata_i),
    .rd_idx_i    (read_idx),
    .rd_pc_o     (rd_pc),
    .rd_instr_o  (rd_instr)
  );

endmodule

// File: tb/tb_riscv_ifq.sv
// Directed bench for riscv_ifq: a PC register and pipelined memory model drive the
// queue; a scoreboard queue of expected PCs is checked by a decoupled decode monitor.
module tb_riscv_ifq;
  import riscv_ifq_pkg::*;

`ifdef RISCV_IFQ_BYPASS_EN
  localparam int FirstLat = 1;
`else
  localparam int FirstLat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i;
  logic        pc_stall_o;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_instr_o;
  logic        dec_ready_i = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          budget = 0;
  int          lat = 1;
  int          fire_cnt = 0;
  int          a_cyc = 0;
  logic [31:0] pc_start = '0;
  logic [31:0] flush_target = '0;
  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          hs_cyc[$];

  riscv_ifq #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_stall_o   (pc_stall_o),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .dec_valid_o  (dec_valid_o),
    .dec_pc_o     (dec_pc_o),
    .dec_instr_o  (dec_instr_o),
    .dec_ready_i  (dec_ready_i)
  );

  always #5 clk = ~clk;

  assign imem_gnt_i = (budget > 0);

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] start, input int l);
    step(1);
    rst = 1'b1; flush_i = 1'b0; dec_ready_i = 1'b0; budget = 0; lat = l; pc_start = start;
    step(2);
    rst = 1'b0; a_cyc = cyc; hs_cyc.delete(); fire_cnt = 0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d entries still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  // PC register plus in-order memory with fixed latency; inputs sampled at negedge.
  initial begin : env
    logic        fire_s, rst_s, stall_s, flush_s;
    logic [31:0] addr_s;
    req_t        r;
    pc_i = '0;
    forever begin
      @(negedge clk);
      fire_s  = imem_req_o && imem_gnt_i;
      addr_s  = imem_addr_o;
      rst_s   = rst;
      stall_s = pc_stall_o;
      flush_s = flush_i;
      assert (!(imem_rvalid_i && !rst && (dut.alloc_q == dut.fill_q) && (dut.drop_cnt_q == 0)))
        else $error("imem_rvalid_i with no outstanding request");
      @(posedge clk);
      cyc++;
      #1;
      if (rst_s) begin
        mem_q.delete();
        pc_i = pc_start;
      end else begin
        if (fire_s) begin
          r.addr = addr_s;
          r.due  = cyc + lat - 1;
          mem_q.push_back(r);
          budget--;
          fire_cnt++;
        end
        if (flush_s) pc_i = flush_target;
        else if (!stall_s) pc_i = pc_i + 32'd4;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        r = mem_q.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr_of(r.addr);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (dec_valid_o && dec_ready_i) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_dec: got pc 0x%08h, required no delivery", dec_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("dec_pc", dec_pc_o, e);
          chk("dec_instr", dec_instr_o, instr_of(e));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state
    step(2);
    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_imem_req", 32'(imem_req_o), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall_o), 32'd1);
    chk("rst_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);

    // Zero-wait memory streaming three fetches
    do_reset(32'h0, 1);
    budget = 3; dec_ready_i = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stream_stall_c%0d", i), 32'(pc_stall_o), 32'd0);
    end
    wait_drain("stream", 30);
    if (hs_cyc.size() >= 3) begin
      chk("first_rsp_latency", 32'(hs_cyc[0] - a_cyc), 32'(FirstLat));
      chk("stream_no_bubbles", 32'(hs_cyc[2] - hs_cyc[0]), 32'd2);
    end else begin
      vectors++; miscompares++;
      $display("FAIL stream_handshakes: got %0d, required 3", hs_cyc.size());
    end

    // Decode stalled: queue fills to DEPTH, then drains in order
    do_reset(32'h0, 1);
    budget = 10; dec_ready_i = 1'b0;
    step(8);
    @(negedge clk);
    chk("full_req_count", 32'(fire_cnt), 32'd4);
    chk("full_imem_req", 32'(imem_req_o), 32'd0);
    chk("full_pc_stall", 32'(pc_stall_o), 32'd1);
    step(1);
    budget = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    dec_ready_i = 1'b1;
    wait_drain("full", 30);

    // Flush with two requests outstanding, 3-cycle memory
    do_reset(32'h0, 3);
    budget = 2; dec_ready_i = 1'b1; flush_target = 32'h100;
    exp_q.push_back(32'h100);
    step(2);
    flush_i = 1'b1; budget = 1;
    step(1);
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    step(1);
    @(negedge clk);
    chk("flush_drop_dec", 32'(dut.drop_cnt_q), 32'd1);
    wait_drain("flush", 30);

    // Flush in the same cycle as the only outstanding response
    do_reset(32'h0, 2);
    budget = 1; dec_ready_i = 1'b1; flush_target = 32'h200;
    exp_q.push_back(32'h200);
    step(2);
    flush_i = 1'b1; budget = 1;
    @(negedge clk);
    chk("flush_rsp_dec_valid", 32'(dec_valid_o), 32'd0);
    step(1);
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_rsp_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    wait_drain("flush_rsp", 30);

    // Reset pulse with entries queued and a response in flight
    do_reset(32'h0, 3);
    budget = 3; dec_ready_i = 1'b0;
    step(4);
    rst = 1'b1; pc_start = 32'h40;
    @(negedge clk);
    chk("midrst_imem_req", 32'(imem_req_o), 32'd0);
    chk("midrst_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("midrst_pc_stall", 32'(pc_stall_o), 32'd1);
    step(1);
    rst = 1'b0; budget = 1; dec_ready_i = 1'b1;
    exp_q.push_back(32'h40);
    @(negedge clk);
    chk("postrst_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("postrst_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    wait_drain("postrst", 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
